apb_reg_slave: RTL and testbench

APB completer that terminates one Pselx line from the AHB-to-APB bridge with a small word-addressed register bank. Inserts a parameterised number of wait states through Pready and returns read data on Prdata. It replaces the pass-through APB model as the real far end of the bridge, so the bridge's wait-state and response paths get exercised.

---
 rtl/apb_slv_pkg.sv | 22 ++
 rtl/apb_reg_slave_if.sv | 31 +++
 rtl/apb_slv_regbank.sv | 39 +++
 rtl/apb_reg_slave.sv | 160 ++++++++++++++++
 tb/tb_apb_reg_slave.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/apb_slv_pkg.sv
// Shared definitions for the APB register completer.
//   state_t     : completer FSM encoding (IDLE, SETUP, ACCESS)
//   CNT_W       : width of the wait-state counter (covers 0..7)
//   DEFAULT_ID  : reset value of the ID_VALUE parameter (read-only register 0)
//   idx_width() : bits needed to index a bank of n word registers
package apb_slv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int unsigned CNT_W = 3;

    localparam logic [31:0] DEFAULT_ID = 32'hA5B0_0001;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB bus between the AHB-to-APB bridge (master) and one completer (slave).
//   Pselx[2:0]   : peripheral selects from the bridge
//   Penable      : access-phase strobe
//   Pwrite       : 1 = write, 0 = read
//   Paddr[31:0]  : byte address
//   Pwdata[31:0] : write data
//   Prdata[31:0] : read data from the completer
//   Pready       : transfer completes while high
//   Pslverr      : error response, qualified by Pready
interface apb_reg_slave_if;

    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    modport master (
        output Pselx, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Pselx, Penable, Pwrite, Paddr, Pwdata,
        output Prdata, Pready, Pslverr
    );

endinterface

// File: rtl/apb_slv_regbank.sv
// Word register bank for the APB completer.
//   Hclk, Hresetin : clock, asynchronous active-high reset (clears registers 1..NUM_REGS-1)
//   we, widx, wdata: write port; writes to index 0 are discarded
//   ridx, rdata    : combinational read port; index 0 returns ID_VALUE
module apb_slv_regbank
    import apb_slv_pkg::*;
#(
    parameter int unsigned  NUM_REGS = 8,
    parameter logic [31:0]  ID_VALUE = DEFAULT_ID,
    localparam int unsigned IW       = idx_width(NUM_REGS)
) (
    input  logic          Hclk,
    input  logic          Hresetin,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [31:0]   wdata,
    input  logic [IW-1:0] ridx,
    output logic [31:0]   rdata
);

    // Entry 0 is never written and never read; it is kept so the array
    // indexes directly with the register index.
    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge Hclk or posedge Hresetin) begin
        if (Hresetin) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (widx != '0)) begin
            regs[widx] <= wdata;
        end
    end

    always_comb begin
        rdata = (ridx == '0) ? ID_VALUE : regs[ridx];
    end

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer terminating one Pselx line with a small register bank and
// WAIT_STATES Pready-low cycles per access phase.
//   Hclk     : clock
//   Hresetin : asynchronous active-high reset
//   bus      : APB slave modport (Pselx/Penable/Pwrite/Paddr/Pwdata in,
//              Prdata/Pready/Pslverr out, all outputs straight from flops)
// Build option APB_SLV_ERR_EN: when defined, misaligned, out-of-range and
// register-0 write accesses complete with Pslverr=1; otherwise Pslverr is 0.
module apb_reg_slave
    import apb_slv_pkg::*;
#(
    parameter int unsigned SEL_BIT     = 0,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = DEFAULT_ID
) (
    input  logic           Hclk,
    input  logic           Hresetin,
    apb_reg_slave_if.slave bus
);

    localparam int unsigned IW = idx_width(NUM_REGS);
    localparam logic [6:0]  NREGS7 = 7'(NUM_REGS);
    // The SETUP-state cycle is already the first access cycle, so ACCESS
    // only has to cover the remaining WAIT_STATES-1 wait cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IW-1:0]    idx_q;
    logic             wr_q;
    logic             bad_q;
    logic [31:0]      wdata_q;
    logic             pready_q;
    logic [31:0]      prdata_q;
    logic             pslverr_q;

    logic          sel;
    logic [IW-1:0] live_idx;
    logic          live_bad;
    logic [IW-1:0] cur_idx;
    logic          cur_wr;
    logic          cur_bad;
    logic [31:0]   rd_value;
    logic [31:0]   rdata_resp;
    logic          err_resp;
    logic          we;
    logic          unused_bits;

    assign sel         = bus.Pselx[SEL_BIT];
    assign unused_bits = ^{bus.Pselx, bus.Paddr[31:8]};

    // Misaligned, or word index beyond the bank (full 6-bit index field).
    assign live_idx = bus.Paddr[IW+1:2];
    assign live_bad = (bus.Paddr[1:0] != 2'b00) || ({1'b0, bus.Paddr[7:2]} >= NREGS7);

    // In IDLE the response is prepared from the live setup-phase bus (only
    // used when WAIT_STATES=0); afterwards only the captured copy is used.
    always_comb begin
        if (state_q == IDLE) begin
            cur_idx = live_idx;
            cur_wr  = bus.Pwrite;
            cur_bad = live_bad;
        end else begin
            cur_idx = idx_q;
            cur_wr  = wr_q;
            cur_bad = bad_q;
        end
        rdata_resp = (!cur_wr && !cur_bad) ? rd_value : '0;
`ifdef APB_SLV_ERR_EN
        err_resp = cur_bad || (cur_wr && (cur_idx == '0));
`else
        err_resp = 1'b0;
`endif
    end

    // Commit at the edge closing the Pready cycle of a live transfer.
    assign we = pready_q && wr_q && sel && bus.Penable && !bad_q;

    always_ff @(posedge Hclk or posedge Hresetin) begin
        if (Hresetin) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            bad_q     <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (sel && !bus.Penable) begin
                        state_q <= SETUP;
                        idx_q   <= live_idx;
                        wr_q    <= bus.Pwrite;
                        bad_q   <= live_bad;
                        wdata_q <= bus.Pwdata;
                        if (WAIT_STATES == 0) begin
                            pready_q  <= 1'b1;
                            prdata_q  <= rdata_resp;
                            pslverr_q <= err_resp;
                        end
                    end
                end
                SETUP: begin
                    if (pready_q) begin
                        state_q <= IDLE;
                    end else if (sel && bus.Penable) begin
                        state_q <= ACCESS;
                        cnt_q   <= CNT_LOAD;
                        if (WAIT_STATES == 1) begin
                            pready_q  <= 1'b1;
                            prdata_q  <= rdata_resp;
                            pslverr_q <= err_resp;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    if (pready_q || !sel || !bus.Penable) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            pready_q  <= 1'b1;
                            prdata_q  <= rdata_resp;
                            pslverr_q <= err_resp;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    apb_slv_regbank #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_regbank (
        .Hclk     (Hclk),
        .Hresetin (Hresetin),
        .we       (we),
        .widx     (idx_q),
        .wdata    (wdata_q),
        .ridx     (cur_idx),
        .rdata    (rd_value)
    );

    assign bus.Prdata  = prdata_q;
    assign bus.Pready  = pready_q;
    assign bus.Pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench: one APB master drives three completers on Pselx bits 0/1/2
// with WAIT_STATES 1/0/3; results are compared against hand-computed values.
module tb_apb_reg_slave;

    localparam logic [31:0] ID = 32'hA5B0_0001;
`ifdef APB_SLV_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif
    localparam int LIMIT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  pselx = 3'b000;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    int          tsel = 0;

    logic        o_pready;
    logic [31:0] o_rdata;
    logic        o_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    apb_reg_slave_if bus0 ();
    apb_reg_slave_if bus1 ();
    apb_reg_slave_if bus2 ();

    assign bus0.Pselx = pselx;  assign bus1.Pselx = pselx;  assign bus2.Pselx = pselx;
    assign bus0.Penable = penable; assign bus1.Penable = penable; assign bus2.Penable = penable;
    assign bus0.Pwrite = pwrite; assign bus1.Pwrite = pwrite; assign bus2.Pwrite = pwrite;
    assign bus0.Paddr = paddr;  assign bus1.Paddr = paddr;  assign bus2.Paddr = paddr;
    assign bus0.Pwdata = pwdata; assign bus1.Pwdata = pwdata; assign bus2.Pwdata = pwdata;

    apb_reg_slave #(.SEL_BIT(0), .NUM_REGS(8), .WAIT_STATES(1), .ID_VALUE(ID)) u_w1 (
        .Hclk(clk), .Hresetin(rst), .bus(bus0)
    );
    apb_reg_slave #(.SEL_BIT(1), .NUM_REGS(8), .WAIT_STATES(0), .ID_VALUE(ID)) u_w0 (
        .Hclk(clk), .Hresetin(rst), .bus(bus1)
    );
    apb_reg_slave #(.SEL_BIT(2), .NUM_REGS(8), .WAIT_STATES(3), .ID_VALUE(ID)) u_w3 (
        .Hclk(clk), .Hresetin(rst), .bus(bus2)
    );

    always_comb begin
        case (tsel)
            0: begin o_pready = bus0.Pready; o_rdata = bus0.Prdata; o_err = bus0.Pslverr; end
            1: begin o_pready = bus1.Pready; o_rdata = bus1.Prdata; o_err = bus1.Pslverr; end
            default: begin o_pready = bus2.Pready; o_rdata = bus2.Prdata; o_err = bus2.Pslverr; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One APB transfer to completer tgt. Address/data are scrambled during the
    // access phase so only the setup capture can produce correct results.
    // rst_cyc>0 pulses reset at that access cycle; for reads, data is then the
    // Prdata value expected just before the pulse.
    task automatic xfer(input int tgt, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input int rst_cyc,
                        output logic [31:0] rd, output logic er, output int lat);
        lat = 99;
        rd  = '0;
        er  = 1'b0;
        @(posedge clk); #1;
        tsel    = tgt;
        pselx   = 3'(1 << tgt);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(posedge clk); #1;
        penable = 1'b1;
        paddr   = addr ^ 32'h0000_001C;
        pwdata  = ~data;
        for (int n = 1; n <= LIMIT; n++) begin
            @(negedge clk);
            if (n == rst_cyc) begin
                if (!wr) check("pre-reset rdata", o_rdata, data);
                rst = 1'b1;
                #1;
                check("async rst pready", {31'b0, o_pready}, 32'd0);
                check("async rst prdata", o_rdata, 32'd0);
                check("async rst pslverr", {31'b0, o_err}, 32'd0);
                #1;
                rst     = 1'b0;
                pselx   = 3'b000;
                penable = 1'b0;
                lat     = n;
                return;
            end
            if (o_pready) begin
                lat = n;
                rd  = o_rdata;
                er  = o_err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        pselx   = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input int tgt, input logic [31:0] addr,
                          input logic [31:0] data, input logic exp_err, input int ws);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xfer(tgt, 1'b1, addr, data, 0, rd, er, lat);
        check({tag, " latency"}, 32'(lat), 32'(ws + 1));
        check({tag, " pslverr"}, {31'b0, er}, {31'b0, exp_err});
    endtask

    task automatic rd_chk(input string tag, input int tgt, input logic [31:0] addr,
                          input logic [31:0] exp, input logic exp_err, input int ws);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xfer(tgt, 1'b0, addr, 32'h0, 0, rd, er, lat);
        check({tag, " latency"}, 32'(lat), 32'(ws + 1));
        check({tag, " prdata"}, rd, exp);
        check({tag, " pslverr"}, {31'b0, er}, {31'b0, exp_err});
    endtask

    // Setup, then Pselx dropped in the first access cycle; Pready must never rise.
    task automatic abort_xfer(input int tgt, input logic [31:0] addr, input logic [31:0] data);
        int hits;
        hits = 0;
        @(posedge clk); #1;
        tsel    = tgt;
        pselx   = 3'(1 << tgt);
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = addr;
        pwdata  = data;
        @(posedge clk); #1;
        pselx   = 3'b000;
        penable = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (o_pready) hits++;
        end
        check("abort pready count", 32'(hits), 32'd0);
        idle();
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tsel = t;
            #1;
            check("reset pready", {31'b0, o_pready}, 32'd0);
            check("reset prdata", o_rdata, 32'd0);
            check("reset pslverr", {31'b0, o_err}, 32'd0);
        end

        // WAIT_STATES=1 completer
        rd_chk("w1 rd id", 0, 32'h0, ID, 1'b0, 1);
        idle();
        wr_chk("w1 wr 0x8", 0, 32'h8, 32'h1234_5678, 1'b0, 1);
        idle();
        rd_chk("w1 rd 0x8", 0, 32'h8, 32'h1234_5678, 1'b0, 1);
        rd_chk("w1 rd 0x4", 0, 32'h4, 32'h0, 1'b0, 1);
        rd_chk("w1 rd 0xC", 0, 32'hC, 32'h0, 1'b0, 1);
        idle();

        // Address-check and register-0 write cases
        wr_chk("w1 wr 0x2 misaligned", 0, 32'h2, 32'h1111_1111, EXP_ERR, 1);
        wr_chk("w1 wr 0x6 misaligned", 0, 32'h6, 32'h2222_2222, EXP_ERR, 1);
        wr_chk("w1 wr 0x20 range", 0, 32'h20, 32'h3333_3333, EXP_ERR, 1);
        wr_chk("w1 wr 0x24 range", 0, 32'h24, 32'h4444_4444, EXP_ERR, 1);
        wr_chk("w1 wr 0x0 ro", 0, 32'h0, 32'h5555_5555, EXP_ERR, 1);
        rd_chk("w1 rd 0x0 after", 0, 32'h0, ID, 1'b0, 1);
        rd_chk("w1 rd 0x4 after", 0, 32'h4, 32'h0, 1'b0, 1);
        rd_chk("w1 rd 0x8 after", 0, 32'h8, 32'h1234_5678, 1'b0, 1);
        rd_chk("w1 rd 0x2 misaligned", 0, 32'h2, 32'h0, EXP_ERR, 1);
        rd_chk("w1 rd 0x20 range", 0, 32'h20, 32'h0, EXP_ERR, 1);
        idle();

        // Reset in the Pready cycle of a read, then in the wait phase of a write
        wr_chk("w1 wr 0x14", 0, 32'h14, 32'hCAFE_F00D, 1'b0, 1);
        xfer(0, 1'b0, 32'h14, 32'hCAFE_F00D, 2, rd, er, lat);
        rd_chk("w1 rd 0x8 post-reset", 0, 32'h8, 32'h0, 1'b0, 1);
        idle();
        xfer(0, 1'b1, 32'h14, 32'h5555_AAAA, 1, rd, er, lat);
        rd_chk("w1 rd 0x14 post-reset", 0, 32'h14, 32'h0, 1'b0, 1);
        idle();

        // WAIT_STATES=0 completer, back-to-back
        wr_chk("w0 wr 0x4", 1, 32'h4, 32'hDEAD_BEEF, 1'b0, 0);
        rd_chk("w0 rd 0x4", 1, 32'h4, 32'hDEAD_BEEF, 1'b0, 0);
        rd_chk("w0 rd id", 1, 32'h0, ID, 1'b0, 0);
        wr_chk("w0 wr 0x0 ro", 1, 32'h0, 32'h0000_0001, EXP_ERR, 0);
        idle();

        // WAIT_STATES=3 completer, normal transfer then abort
        wr_chk("w3 wr 0x18", 2, 32'h18, 32'h0BAD_CAFE, 1'b0, 3);
        rd_chk("w3 rd 0x18", 2, 32'h18, 32'h0BAD_CAFE, 1'b0, 3);
        idle();
        abort_xfer(2, 32'h10, 32'hFFFF_FFFF);
        rd_chk("w3 rd 0x10 after abort", 2, 32'h10, 32'h0, 1'b0, 3);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
